// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer placed in front of the shared up/down preloadable counter.
// Loads a start value, steers the counter to an end value, optionally
// ping-pongs between the two bounds, and freezes the counter between sweeps
// by continuously preloading the held value.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | counter frozen at hold_q, waiting for start
// LOAD    | one cycle, counter preloaded with start_q
// RUN_FWD | counter steered toward end_q
// RUN_REV | counter steered back toward start_q (bounce only)
// DONE    | one-cycle done pulse, counter frozen at hold_q
module counter_sweep_ctrl #(
  parameter int WIDTH  = 32,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst_s,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  start_val,
  input  logic [WIDTH-1:0]  end_val,
  input  logic              bounce,
  input  logic [PASS_W-1:0] passes,
  input  logic [WIDTH-1:0]  cnt_dout,
  output logic [WIDTH-1:0]  cnt_din,
  output logic              cnt_preload,
  output logic              cnt_asc,
  output logic              busy,
  output logic              done,
  output logic [PASS_W-1:0] pass_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN_FWD = 3'd2,
    S_RUN_REV = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic [WIDTH-1:0]  start_q, start_d;
  logic [WIDTH-1:0]  end_q, end_d;
  logic              bounce_q, bounce_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic              dir_q, dir_d;

  logic [WIDTH-1:0]  target;
  logic              run_dir;
  logic [PASS_W-1:0] pass_inc;

  assign pass_cnt = pass_cnt_q;

  // State and captured sweep parameters.
  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      start_q    <= '0;
      end_q      <= '0;
      bounce_q   <= 1'b0;
      passes_q   <= '0;
      pass_cnt_q <= '0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      start_q    <= start_d;
      end_q      <= end_d;
      bounce_q   <= bounce_d;
      passes_q   <= passes_d;
      pass_cnt_q <= pass_cnt_d;
      dir_q      <= dir_d;
    end
  end

  // Next-state and counter control decode.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    start_d     = start_q;
    end_d       = end_q;
    bounce_d    = bounce_q;
    passes_d    = passes_q;
    pass_cnt_d  = pass_cnt_q;
    dir_d       = dir_q;
    cnt_preload = 1'b1;
    cnt_din     = hold_q;
    cnt_asc     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    target      = (state_q == S_RUN_REV) ? start_q : end_q;
    run_dir     = (state_q == S_RUN_REV) ? ~dir_q : dir_q;
    pass_inc    = pass_cnt_q + PASS_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_d    = start_val;
          end_d      = end_val;
          bounce_d   = bounce;
          passes_d   = (passes == '0) ? PASS_W'(1) : passes;
          pass_cnt_d = '0;
          dir_d      = (end_val > start_val);
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        busy    = 1'b1;
        cnt_din = start_q;
        if (abort) begin
          cnt_din = cnt_dout;
          hold_d  = cnt_dout;
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN_FWD;
        end
      end
      S_RUN_FWD, S_RUN_REV: begin
        busy = 1'b1;
        if (abort) begin
          cnt_din = cnt_dout;
          hold_d  = cnt_dout;
          state_d = S_IDLE;
        end else if (cnt_dout != target) begin
          // Steer by magnitude so that the one-step excursion of an
          // equal-bounds bounce always heads back to its target.
          cnt_preload = 1'b0;
          cnt_asc     = (target > cnt_dout);
        end else begin
          pass_cnt_d = pass_inc;
          if ((pass_inc == passes_q) || !bounce_q) begin
            cnt_din = target;
            hold_d  = target;
            state_d = S_DONE;
          end else begin
            cnt_preload = 1'b0;
            cnt_asc     = ~run_dir;
            state_d     = (state_q == S_RUN_FWD) ? S_RUN_REV : S_RUN_FWD;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: wraps it around a behavioural model of the
// shared preloadable up/down counter and scoreboards the counter trajectory.
module tb_counter_sweep_ctrl;

  localparam int WIDTH  = 32;
  localparam int PASS_W = 8;

  logic              clk = 1'b0;
  logic              rst_s;
  logic              start;
  logic              abort;
  logic [WIDTH-1:0]  start_val;
  logic [WIDTH-1:0]  end_val;
  logic              bounce;
  logic [PASS_W-1:0] passes;
  logic [WIDTH-1:0]  cnt_dout = '0;
  logic [WIDTH-1:0]  cnt_din;
  logic              cnt_preload;
  logic              cnt_asc;
  logic              busy;
  logic              done;
  logic [PASS_W-1:0] pass_cnt;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  counter_sweep_ctrl #(.WIDTH(WIDTH), .PASS_W(PASS_W)) dut (
    .clk         (clk),
    .rst_s       (rst_s),
    .start       (start),
    .abort       (abort),
    .start_val   (start_val),
    .end_val     (end_val),
    .bounce      (bounce),
    .passes      (passes),
    .cnt_dout    (cnt_dout),
    .cnt_din     (cnt_din),
    .cnt_preload (cnt_preload),
    .cnt_asc     (cnt_asc),
    .busy        (busy),
    .done        (done),
    .pass_cnt    (pass_cnt)
  );

  always #5 clk = ~clk;

  // Shared counter model: preload wins, otherwise count up or down.
  always @(posedge clk) begin
    if (cnt_preload)  cnt_dout <= cnt_din;
    else if (cnt_asc) cnt_dout <= cnt_dout + 1;
    else              cnt_dout <= cnt_dout - 1;
  end

  task automatic test_reset();
    int n;
    rst_s = 1'b0; start = 1'b0; abort = 1'b0; bounce = 1'b0;
    start_val = '0; end_val = '0; passes = '0;
    #3;
    total++;
    if (cnt_preload !== 1'b1 || cnt_din !== '0 || busy !== 1'b0 || done !== 1'b0 || pass_cnt !== '0) begin
      bad++;
      $display("FAIL reset_state: preload=%b din=%0d busy=%b done=%b pass=%0d, want 1 0 0 0 0",
               cnt_preload, cnt_din, busy, done, pass_cnt);
    end
    @(negedge clk); rst_s = 1'b1;
    // Reset mid-sweep with the counter ascending through 5.
    start_val = 0; end_val = 10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (cnt_dout != 5 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n >= 20) begin bad++; $display("FAIL reset_reach5: timeout, cnt=%0d want 5", cnt_dout); end
    rst_s = 1'b0;
    #1;
    total++;
    if (cnt_preload !== 1'b1 || cnt_din !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: preload=%b din=%0d busy=%b, want 1 0 0", cnt_preload, cnt_din, busy);
    end
    @(negedge clk); rst_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || cnt_preload !== 1'b1 || cnt_dout !== '0) begin
        bad++;
        $display("FAIL reset_idle: busy=%b preload=%b cnt=%0d, want 0 1 0", busy, cnt_preload, cnt_dout);
      end
    end
  endtask

  task automatic run_sweep(input logic [WIDTH-1:0] sv, input logic [WIDTH-1:0] ev,
                           input logic b, input logic [PASS_W-1:0] p, input string name);
    logic [WIDTH-1:0] pos, tgt, oth, tmp, cur;
    int np, last, dones;
    exp_q.delete();
    np  = b ? ((p == 0) ? 1 : int'(p)) : 1;
    pos = sv; tgt = ev; oth = sv;
    exp_q.push_back(pos);
    for (int i = 0; i < np; i++) begin
      while (pos != tgt) begin
        pos = (tgt > pos) ? pos + 1 : pos - 1;
        exp_q.push_back(pos);
      end
      tmp = tgt; tgt = oth; oth = tmp;
    end
    last  = exp_q.size() - 1;
    dones = 0;
    @(negedge clk);
    start_val = sv; end_val = ev; bounce = b; passes = p; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= last + 3; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      total++;
      if (done !== (k == last + 2)) begin
        bad++; $display("FAIL %s_done k=%0d: got %b want %b", name, k, done, (k == last + 2));
      end
      if (k <= last + 1) begin
        cur = exp_q.pop_front();
        total++;
        if (cnt_dout !== cur || busy !== 1'b1) begin
          bad++; $display("FAIL %s_traj k=%0d: cnt=%0d busy=%b want cnt=%0d busy=1", name, k, cnt_dout, busy, cur);
        end
        if (exp_q.size() > 0) begin
          total++;
          if (cnt_preload !== 1'b0 || cnt_asc !== (exp_q[0] > cur)) begin
            bad++; $display("FAIL %s_steer k=%0d: preload=%b asc=%b want 0 %b", name, k, cnt_preload, cnt_asc, (exp_q[0] > cur));
          end
        end
      end else begin
        total++;
        if (cnt_dout !== pos || busy !== 1'b0) begin
          bad++; $display("FAIL %s_end k=%0d: cnt=%0d busy=%b want cnt=%0d busy=0", name, k, cnt_dout, busy, pos);
        end
      end
      if (k == last + 2) begin
        total++;
        if (pass_cnt !== PASS_W'(np)) begin
          bad++; $display("FAIL %s_passes: got %0d want %0d", name, pass_cnt, np);
        end
      end
    end
    total++;
    if (dones != 1) begin bad++; $display("FAIL %s_done_count: got %0d want 1", name, dones); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (cnt_dout !== pos || cnt_preload !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL %s_hold: cnt=%0d preload=%b done=%b want %0d 1 0", name, cnt_dout, cnt_preload, done, pos);
      end
    end
  endtask

  task automatic test_ascend();  run_sweep(3, 7, 1'b0, 0, "ascend");       endtask
  task automatic test_descend(); run_sweep(10, 6, 1'b0, 0, "descend");     endtask
  task automatic test_bounce();  run_sweep(2, 4, 1'b1, 3, "bounce");       endtask
  task automatic test_equal();   run_sweep(9, 9, 1'b0, 0, "equal");        endtask

  task automatic test_abort();
    logic [WIDTH-1:0] prev;
    int n;
    logic hit;
    @(negedge clk);
    start_val = 0; end_val = 100; bounce = 1'b0; passes = 0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    prev = cnt_dout;
    total++;
    if (cnt_dout !== 0) begin bad++; $display("FAIL abort_load: cnt=%0d want 0", cnt_dout); end
    hit = 1'b0;
    for (n = 0; n < 40 && !hit; n++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (cnt_dout !== prev + 1 || done !== 1'b0) begin
        bad++; $display("FAIL abort_run: cnt=%0d done=%b want %0d 0", cnt_dout, done, prev + 1);
      end
      prev = cnt_dout;
      if (cnt_dout == 10) begin start_val = 50; end_val = 60; start = 1'b1; end
      if (cnt_dout == 20) begin abort = 1'b1; hit = 1'b1; end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL abort_reach20: timeout cnt=%0d want 20", cnt_dout); end
    @(negedge clk); abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (cnt_dout !== 20 || busy !== 1'b0 || done !== 1'b0 || cnt_preload !== 1'b1 || pass_cnt !== 0) begin
        bad++; $display("FAIL abort_frozen: cnt=%0d busy=%b done=%b preload=%b pass=%0d want 20 0 0 1 0",
                        cnt_dout, busy, done, cnt_preload, pass_cnt);
      end
      @(negedge clk);
    end
    run_sweep(20, 22, 1'b0, 0, "restart");
  endtask

  initial begin
    test_reset();
    test_ascend();
    test_descend();
    test_bounce();
    test_abort();
    test_equal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
